hier_rr_arbiter: RTL and testbench

HIER_RR_ARBITER -- requirements
Module: hier_rr_arbiter

---
 rtl/hier_rr_arbiter_if.sv | 46 ++++
 rtl/hier_rr_arbiter.sv | 172 +++++++++++++++++
 tb/tb_hier_rr_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/hier_rr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : hier_rr_arbiter_if
//  Purpose  : Request/grant bundle for the hierarchical round-robin arbiter.
//             The master drives the requests and the release strobe. The
//             slave (the arbiter) returns the grant, its encoded index, a
//             valid flag and the timeout pulse.
//  Signals  : req[N]        request vector, one bit per requester
//             done          current owner releases its grant
//             grant[N]      one-hot grant, zero when idle
//             grant_valid   grant is non-zero
//             grant_id      encoded index of grant, zero when idle
//             timeout       tenure ended by the hold limit
//  Revision : 1.0  initial release
// ============================================================================
interface hier_rr_arbiter_if #(
  parameter int N = 16
) ();
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  req;
  logic          done;
  logic [N-1:0]  grant;
  logic          grant_valid;
  logic [IW-1:0] grant_id;
  logic          timeout;

  modport master (
    output req,
    output done,
    input  grant,
    input  grant_valid,
    input  grant_id,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output grant,
    output grant_valid,
    output grant_id,
    output timeout
  );
endinterface
`default_nettype wire

// File: rtl/hier_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : hier_rr_arbiter
//  Purpose  : Two-level round-robin arbiter. Each group of GROUP_SIZE
//             requesters has its own leaf pointer, and one root pointer
//             rotates among the GROUPS groups. A granted owner keeps the
//             grant until it asserts done, drops its request, or has held
//             the grant for MAX_HOLD cycles (0 = no limit). Handover to the
//             next requester is back-to-back.
//  Ports    : clk          rising-edge clock
//             rst_n        asynchronous active-low reset
//             bus (slave)  req/done in, grant/grant_valid/grant_id/timeout out
//  Revision : 1.0  initial release
// ============================================================================
module hier_rr_arbiter #(
  parameter int GROUPS     = 4,
  parameter int GROUP_SIZE = 4,
  parameter int MAX_HOLD   = 16
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  hier_rr_arbiter_if.slave bus
);

  localparam int N  = GROUPS * GROUP_SIZE;
  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int LW = $clog2(GROUP_SIZE);
  localparam int GW = $clog2(GROUPS);
  localparam int TW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_BUSY = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]    r_state;
  logic [N-1:0]  r_grant;
  logic          r_grant_valid;
  logic [IW-1:0] r_grant_id;
  logic          r_timeout;
  logic [TW-1:0] r_tenure;
  logic [GW-1:0] r_root_ptr;
  logic [LW-1:0] r_leaf_ptr [GROUPS];

  // --------------------------------------------------------------------------
  // Release detection
  // --------------------------------------------------------------------------
  logic w_owner_req;
  logic w_tenure_hit;
  logic w_release;
  logic w_arbitrate;

  assign w_owner_req = |(bus.req & r_grant);
  // r_tenure counts completed BUSY cycles after the issuing edge, so the
  // owner's MAX_HOLD-th visible cycle is the one where it equals MAX_HOLD-1.
  assign w_tenure_hit = (MAX_HOLD != 0) && (r_tenure >= TW'(MAX_HOLD - 1));
  assign w_release    = (r_state == S_BUSY) &&
                        (bus.done || !w_owner_req || w_tenure_hit);
  assign w_arbitrate  = (r_state == S_IDLE) || w_release;

  // --------------------------------------------------------------------------
  // Arbitration: the current owner is masked out during a handover.
  // --------------------------------------------------------------------------
  logic [N-1:0]                       w_arb_req;
  logic [GROUPS-1:0][GROUP_SIZE-1:0]  w_req2d;
  logic                               w_any;
  logic [GW-1:0]                      w_win_grp;
  logic [LW-1:0]                      w_win_leaf;
  logic [IW-1:0]                      w_win_id;
  logic [GW-1:0]                      w_root_nxt;
  logic [LW-1:0]                      w_leaf_nxt;

  assign w_arb_req = (r_state == S_BUSY) ? (bus.req & ~r_grant) : bus.req;
  assign w_req2d   = w_arb_req;

  always_comb begin
    logic [LW:0]   w_idx;
    logic [GW:0]   w_gi;
    logic [GROUPS-1:0] w_has;
    logic [LW-1:0] w_cand [GROUPS];

    w_idx     = '0;
    w_gi      = '0;
    w_has     = '0;
    w_any     = 1'b0;
    w_win_grp = r_root_ptr;

    // Leaf search: scanning offsets from high to low lets the smallest
    // offset from the pointer overwrite the others and win.
    for (int g = 0; g < GROUPS; g++) begin
      w_cand[g] = r_leaf_ptr[g];
      for (int k = GROUP_SIZE - 1; k >= 0; k--) begin
        w_idx = {1'b0, r_leaf_ptr[g]} + (LW + 1)'(k);
        if (w_idx >= (LW + 1)'(GROUP_SIZE)) begin
          w_idx = w_idx - (LW + 1)'(GROUP_SIZE);
        end
        if (w_req2d[g][w_idx[LW-1:0]]) begin
          w_cand[g] = w_idx[LW-1:0];
          w_has[g]  = 1'b1;
        end
      end
    end

    // Root search over groups that hold a candidate, same wrap rule.
    for (int k = GROUPS - 1; k >= 0; k--) begin
      w_gi = {1'b0, r_root_ptr} + (GW + 1)'(k);
      if (w_gi >= (GW + 1)'(GROUPS)) begin
        w_gi = w_gi - (GW + 1)'(GROUPS);
      end
      if (w_has[w_gi[GW-1:0]]) begin
        w_win_grp = w_gi[GW-1:0];
        w_any     = 1'b1;
      end
    end

    w_win_leaf = w_cand[w_win_grp];
  end

  assign w_win_id   = IW'(w_win_grp) * IW'(GROUP_SIZE) + IW'(w_win_leaf);
  assign w_root_nxt = (w_win_grp == GW'(GROUPS - 1)) ? '0 : w_win_grp + GW'(1);
  assign w_leaf_nxt = (w_win_leaf == LW'(GROUP_SIZE - 1)) ? '0 : w_win_leaf + LW'(1);

  // --------------------------------------------------------------------------
  // Sequential update
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_grant       <= '0;
      r_grant_valid <= 1'b0;
      r_grant_id    <= '0;
      r_timeout     <= 1'b0;
      r_tenure      <= '0;
      r_root_ptr    <= '0;
      for (int g = 0; g < GROUPS; g++) begin
        r_leaf_ptr[g] <= '0;
      end
    end else begin
      r_timeout <= 1'b0;
      if (w_arbitrate) begin
        // Only a pure hold-limit release (owner still requesting, no done)
        // is reported as a timeout.
        r_timeout <= w_release && w_tenure_hit && !bus.done && w_owner_req;
        if (w_any) begin
          r_state                <= S_BUSY;
          r_grant                <= {{(N-1){1'b0}}, 1'b1} << w_win_id;
          r_grant_valid          <= 1'b1;
          r_grant_id             <= w_win_id;
          r_tenure               <= '0;
          r_root_ptr             <= w_root_nxt;
          r_leaf_ptr[w_win_grp]  <= w_leaf_nxt;
        end else begin
          r_state       <= S_IDLE;
          r_grant       <= '0;
          r_grant_valid <= 1'b0;
          r_grant_id    <= '0;
          r_tenure      <= '0;
        end
      end else if (r_tenure != TW'(MAX_HOLD)) begin
        r_tenure <= r_tenure + TW'(1);
      end
    end
  end

  assign bus.grant       = r_grant;
  assign bus.grant_valid = r_grant_valid;
  assign bus.grant_id    = r_grant_id;
  assign bus.timeout     = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_hier_rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hier_rr_arbiter
//  Purpose  : Self-checking bench for hier_rr_arbiter. A driver issues one
//             stimulus per cycle on the falling edge and pushes the expected
//             next-cycle outputs from a reference model into a queue; a
//             monitor pops and compares one entry after every rising edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_hier_rr_arbiter;

  localparam int GROUPS     = 4;
  localparam int GROUP_SIZE = 4;
  localparam int MAX_HOLD   = 16;
  localparam int N          = GROUPS * GROUP_SIZE;
  localparam int IW         = $clog2(N);

  typedef struct packed {
    logic [N-1:0]  grant;
    logic          valid;
    logic [IW-1:0] id;
    logic          to;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  hier_rr_arbiter_if #(.N(N)) bif ();

  hier_rr_arbiter #(
    .GROUPS    (GROUPS),
    .GROUP_SIZE(GROUP_SIZE),
    .MAX_HOLD  (MAX_HOLD)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bif.slave)
  );

  always #5 clk = ~clk;

  int   total = 0;
  int   bad   = 0;
  exp_t q[$];

  int seq038[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // --------------------------------------------------------------------------
  // Reference model: owner index (-1 when idle), cycles the owner has shown
  // its grant, and the round-robin pointers as plain integers.
  // --------------------------------------------------------------------------
  int m_owner;
  int m_held;
  int m_root;
  int m_leaf[GROUPS];

  function automatic void model_reset();
    m_owner = -1;
    m_held  = 0;
    m_root  = 0;
    for (int g = 0; g < GROUPS; g++) m_leaf[g] = 0;
  endfunction

  function automatic int pick(input logic [N-1:0] rq);
    int g;
    int i;
    for (int k = 0; k < GROUPS; k++) begin
      g = (m_root + k) % GROUPS;
      for (int j = 0; j < GROUP_SIZE; j++) begin
        i = (m_leaf[g] + j) % GROUP_SIZE;
        if (rq[g * GROUP_SIZE + i]) begin
          m_root    = (g + 1) % GROUPS;
          m_leaf[g] = (i + 1) % GROUP_SIZE;
          return g * GROUP_SIZE + i;
        end
      end
    end
    return -1;
  endfunction

  function automatic exp_t model_step(input logic [N-1:0] rq, input logic dn);
    exp_t         e;
    bit           rel;
    bit           to;
    logic [N-1:0] masked;
    rel = 1'b0;
    to  = 1'b0;
    if (m_owner >= 0) begin
      if (dn) rel = 1'b1;
      else if (!rq[m_owner]) rel = 1'b1;
      else if (MAX_HOLD != 0 && m_held >= MAX_HOLD) begin
        rel = 1'b1;
        to  = 1'b1;
      end
    end
    if (m_owner >= 0 && !rel) begin
      m_held++;
    end else begin
      masked = rq;
      if (m_owner >= 0) masked[m_owner] = 1'b0;
      m_owner = pick(masked);
      m_held  = 1;
    end
    e       = '0;
    e.to    = to;
    if (m_owner >= 0) begin
      e.grant[m_owner] = 1'b1;
      e.valid          = 1'b1;
      e.id             = IW'(m_owner);
    end
    return e;
  endfunction

  // --------------------------------------------------------------------------
  // Driver helpers
  // --------------------------------------------------------------------------
  task automatic drive(input logic [N-1:0] rq, input logic dn);
    rst_n    = 1'b1;
    bif.req  = rq;
    bif.done = dn;
    q.push_back(model_step(rq, dn));
  endtask

  task automatic cycle(input logic [N-1:0] rq, input logic dn);
    @(negedge clk);
    drive(rq, dn);
  endtask

  task automatic reset_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      rst_n    = 1'b0;
      bif.req  = '0;
      bif.done = 1'b0;
      model_reset();
      q.push_back('0);
    end
  endtask

  // --------------------------------------------------------------------------
  // Monitor
  // --------------------------------------------------------------------------
  int waitc[N];
  int max_wait = 0;

  initial begin
    exp_t e;
    int   enc;
    for (int i = 0; i < N; i++) waitc[i] = 0;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (rst_n && bif.req[i] && !bif.grant[i]) waitc[i]++;
        else waitc[i] = 0;
        if (waitc[i] > max_wait) max_wait = waitc[i];
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("grant", 32'(bif.grant), 32'(e.grant));
        chk("grant_valid", 32'(bif.grant_valid), 32'(e.valid));
        chk("grant_id", 32'(bif.grant_id), 32'(e.id));
        chk("timeout", 32'(bif.timeout), 32'(e.to));
        chk("onehot", 32'($onehot0(bif.grant)), 32'd1);
        chk("req_qualified", 32'((bif.grant & ~bif.req) == '0), 32'd1);
        enc = 0;
        for (int i = 0; i < N; i++) if (bif.grant[i]) enc = i;
        chk("id_encode", 32'(bif.grant_id), 32'(enc));
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin
    logic [N-1:0] cur;
    bif.req  = '0;
    bif.done = 1'b0;
    model_reset();

    // Done pulses while idle must not move any pointer.
    reset_cycles(2);
    cycle('0, 1'b1);
    cycle('0, 1'b0);
    cycle('0, 1'b1);

    // All requesting, done every cycle: fixed interleaved order.
    for (int k = 0; k < 34; k++) begin
      @(negedge clk);
      if (k >= 1) chk("rr_order", 32'(bif.grant_id), 32'(seq038[(k - 1) % 16]));
      drive(16'hFFFF, 1'b1);
    end

    // Single requester held: hold limit, timeout pulse, one idle cycle.
    reset_cycles(2);
    cycle(16'h0001, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 16) chk("hold_last", 32'(bif.grant), 32'h0001);
      if (k == 17) begin
        chk("hold_gap", 32'(bif.grant), 32'h0000);
        chk("hold_timeout", 32'(bif.timeout), 32'd1);
      end
      if (k == 18) chk("hold_regrant", 32'(bif.grant), 32'h0001);
      drive(16'h0001, 1'b0);
    end

    // Owner drops its request: immediate handover.
    reset_cycles(2);
    cycle(16'h0008, 1'b0);
    @(negedge clk);
    chk("drop_owner", 32'(bif.grant), 32'h0008);
    drive(16'h0108, 1'b0);
    cycle(16'h0100, 1'b0);
    @(negedge clk);
    chk("drop_handover", 32'(bif.grant), 32'h0100);
    drive(16'h0100, 1'b0);

    // Asynchronous reset in the middle of a tenure.
    reset_cycles(2);
    cycle(16'h0400, 1'b0);
    for (int k = 0; k < 3; k++) cycle(16'h0400, 1'b0);
    @(negedge clk);
    chk("pre_reset_grant", 32'(bif.grant), 32'h0400);
    rst_n = 1'b0;
    #1;
    chk("async_grant", 32'(bif.grant), 32'h0);
    chk("async_valid", 32'(bif.grant_valid), 32'h0);
    chk("async_id", 32'(bif.grant_id), 32'h0);
    chk("async_timeout", 32'(bif.timeout), 32'h0);
    model_reset();
    q.push_back('0);
    cycle(16'hFFFF, 1'b0);
    @(negedge clk);
    chk("post_reset_id", 32'(bif.grant_id), 32'h0);
    chk("post_reset_valid", 32'(bif.grant_valid), 32'h1);
    drive(16'hFFFF, 1'b1);

    // Random traffic: requests are held until served, owners may drop.
    cur = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!cur[i] && $urandom_range(0, 7) == 0) cur[i] = 1'b1;
      end
      if (m_owner >= 0 && $urandom_range(0, 5) == 0) cur[m_owner] = 1'b0;
      cycle(cur, $urandom_range(0, 4) == 0);
    end

    @(posedge clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);
    chk("max_wait_ok", 32'(max_wait <= N * MAX_HOLD), 32'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
